// File: rtl/state_mux_reg_if.sv
// Request/response bundle for state_mux_reg: source states and select in,
// registered state out. Optional XOR ports exist only with STATE_MUX_XOR_EN.
interface state_mux_reg_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned WORDS   = 5,
    parameter int unsigned WIDTH   = 64
);
    localparam int unsigned SEL_W = $clog2(NUM_SRC);

    logic [NUM_SRC*WORDS*WIDTH-1:0] src_i;
    logic [SEL_W-1:0]               sel_i;
    logic                           valid_i;
    logic                           ready_o;
`ifdef STATE_MUX_XOR_EN
    logic                           xor_en_i;
    logic [WIDTH-1:0]               xor_data_i;
`endif
    logic [WORDS*WIDTH-1:0]         state_o;
    logic                           valid_o;
    logic                           ready_i;

`ifdef STATE_MUX_XOR_EN
    modport slave (
        input  src_i, sel_i, valid_i, xor_en_i, xor_data_i, ready_i,
        output ready_o, state_o, valid_o
    );
    modport master (
        output src_i, sel_i, valid_i, xor_en_i, xor_data_i, ready_i,
        input  ready_o, state_o, valid_o
    );
`else
    modport slave (
        input  src_i, sel_i, valid_i, ready_i,
        output ready_o, state_o, valid_o
    );
    modport master (
        output src_i, sel_i, valid_i, ready_i,
        input  ready_o, state_o, valid_o
    );
`endif
endinterface

// File: rtl/state_mux_reg.sv
// Registered NUM_SRC-way ASCON state selector with optional lane XOR injection
// (STATE_MUX_XOR_EN) and a valid/ready output stage backed by a one-entry skid.
module state_mux_reg #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned WORDS    = 5,
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned XOR_WORD = 0
) (
    input  logic                  clock_i,
    input  logic                  resetb_i,
    state_mux_reg_if.slave        bus,
    output logic                  err_o,
    output logic [15:0]           xfer_cnt_o
);
    localparam int unsigned SEL_W   = $clog2(NUM_SRC);
    localparam int unsigned STATE_W = WORDS * WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    buf_state_e         state_q;
    buf_state_e         state_d;

    logic [STATE_W-1:0] sel_state;
    logic               sel_bad;
    logic               accept;
    logic               xfer;

    logic               load_main_new;
    logic               load_main_skid;
    logic               load_skid;

    logic [STATE_W-1:0] main_q;
    logic [STATE_W-1:0] skid_q;
    logic               err_q;
    logic [15:0]        cnt_q;

    // XOR_WORD has to name an existing lane even when injection is compiled out.
    if (XOR_WORD >= WORDS) begin : g_xor_word_out_of_range
    end

    // Handshakes depend on registered state only, never on ready_i for ready_o.
    assign accept = bus.valid_i && (state_q != FULL);
    assign xfer   = (state_q != EMPTY) && bus.ready_i;

    // Out-of-range selects can only exist when NUM_SRC is not a power of two.
    if (NUM_SRC == (1 << SEL_W)) begin : g_sel_full
        assign sel_bad = 1'b0;
    end else begin : g_sel_partial
        localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SRC - 1);
        assign sel_bad = (bus.sel_i > LAST_SEL);
    end

    always_comb begin
        sel_state = bus.src_i[STATE_W-1:0];
        for (int unsigned k = 1; k < NUM_SRC; k++) begin
            if (bus.sel_i == SEL_W'(k)) begin
                sel_state = bus.src_i[k*STATE_W +: STATE_W];
            end
        end
`ifdef STATE_MUX_XOR_EN
        if (bus.xor_en_i) begin
            sel_state[XOR_WORD*WIDTH +: WIDTH] =
                sel_state[XOR_WORD*WIDTH +: WIDTH] ^ bus.xor_data_i;
        end
`endif
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) state_d = ONE;
            end
            ONE: begin
                if (accept && !xfer)      state_d = FULL;
                else if (!accept && xfer) state_d = EMPTY;
            end
            FULL: begin
                if (xfer) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        bus.valid_o    = (state_q != EMPTY);
        bus.ready_o    = (state_q != FULL);
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                load_main_new = accept;
            end
            ONE: begin
                load_main_new = accept && xfer;
                load_skid     = accept && !xfer;
            end
            FULL: begin
                load_main_skid = xfer;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            main_q <= '0;
            skid_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (load_main_new) begin
                main_q <= sel_state;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end

            if (load_skid) begin
                skid_q <= sel_state;
            end else if (load_main_skid) begin
                skid_q <= '0;
            end

            if (accept && sel_bad) begin
                err_q <= 1'b1;
            end

            if (xfer) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.state_o = main_q;
    assign err_o       = err_q;
    assign xfer_cnt_o  = cnt_q;

endmodule

// File: doc/state_mux_reg.md
# state_mux_reg

Parametrised, registered state selector for the ASCON datapath: it selects one of `NUM_SRC` full permutation states (for example initial state, permutation output, or finalisation state), optionally XORs a data word into one lane, and delivers the result through a valid/ready output stage with a one-entry skid buffer. It sits in front of the state register / permutation round logic and replaces the fixed two-input, purely combinational state mux.

## Interface
- `NUM_SRC`, 2: number of candidate states; minimum 2.
- `WORDS`, 5: 64-bit lanes per state (ASCON: 5).
- `WIDTH`, 64: bits per lane.
- `XOR_WORD`, 0: lane index that receives the optional XOR injection; must be less than `WORDS`.
- `SEL_W`, `$clog2(NUM_SRC)`: select width; derived, never overridden.

- `clock_i` in, 1: single clock; all state updates on the rising edge.
- `resetb_i` in, 1: asynchronous, active-low reset.
- `src_i` in, `NUM_SRC*WORDS*WIDTH`: flattened sources. Source k occupies bits `[(k+1)*WORDS*WIDTH-1 : k*WORDS*WIDTH]`. Lane 0 of each source is its least-significant lane.
- `sel_i` in, `SEL_W`: source index, sampled on accept.
- `valid_i` in, 1: input request.
- `ready_o` out, 1: block can accept a request.
- `xor_en_i` in, 1: enables XOR injection for this request (macro only).
- `xor_data_i` in, `WIDTH`: word XORed into lane `XOR_WORD` (macro only).
- `state_o` out, `WORDS*WIDTH`: selected state.
- `valid_o` out, 1: `state_o` holds valid data.
- `ready_i` in, 1: downstream consumer accepts the output.
- `err_o` out, 1: sticky flag set by an out-of-range select.
- `xfer_cnt_o` out, 16: count of completed output transfers.

## Operation
- Accept occurs when `valid_i && ready_o`. Output transfer occurs when `valid_o && ready_i`.
- Selected value: `src_i` slice at index `sel_i`.
  - If `sel_i >= NUM_SRC` (only possible when `NUM_SRC` is not a power of two), source 0 is used and `err_o` is set.
  - `err_o` stays high until reset.
- XOR injection: lane `XOR_WORD` of the selected value is replaced by itself XOR `xor_data_i` when `xor_en_i` is set. All other lanes pass through unchanged.
- Storage is two registers: the main register (`state_o`/`valid_o`) and the skid register (`skid_q`/`skid_v`).
- Buffer states and transitions:
  - EMPTY (`valid_o`=0):
    - Accept → load main; go to ONE.
  - ONE (`valid_o`=1, `skid_v`=0):
    - Transfer and accept together → load main; stay in ONE.
    - Transfer only → go to EMPTY.
    - Accept only → load skid; go to FULL.
  - FULL (`valid_o`=1, `skid_v`=1):
    - Transfer → skid moves to main; skid clears; go to ONE.
    - No transfer → hold.
- `ready_o = !skid_v`. It is combinational from registered state only; there is no combinational path from `ready_i`.
- `xfer_cnt_o` increments by 1 on each transfer and wraps from 0xFFFF to 0x0000.
- Reset values: `state_o`=0, `valid_o`=0, `skid_q`=0, `skid_v`=0, `err_o`=0, `xfer_cnt_o`=0. `ready_o`=1 while in reset and after reset.
- Reset asserted mid-operation discards both entries immediately. No partial transfer is reported.

## Timing
- Latency: an accept in cycle N gives `valid_o` with data in cycle N+1, when the buffer was EMPTY or transferring.
- Throughput: one state per cycle while `ready_i` stays high.
- Backpressure: at most two states are in flight. `ready_o` drops in the cycle after the skid register fills, and rises in the cycle after the FULL→ONE transfer.
- `state_o` and `valid_o` are stable while `valid_o && !ready_i`.
- `err_o` rises in the cycle after the offending accept. Non-accepted requests never set it.

## Configuration
- `STATE_MUX_XOR_EN`
  - Defined: the `xor_en_i` and `xor_data_i` ports exist and injection operates as described.
  - Undefined: both ports are absent and the selected state passes unmodified. Area and timing drop by one `WIDTH`-bit XOR lane.

## Test plan
- Reset, then `NUM_SRC`=2 with src0 = {5{64'h0123456789ABCDEF}} and src1 = {5{64'hFEDCBA9876543210}}. Pulse `sel_i`=0 then 1, with `ready_i`=1 → `state_o` is src0 in the next cycle, then src1 one cycle later; `xfer_cnt_o`=2.
- Hold `ready_i`=0 and issue 3 requests → the first two are accepted, `ready_o`=0 on the third. Raise `ready_i` → the outputs drain in order, then `ready_o`=1.
- Macro defined, `XOR_WORD`=0, `xor_data_i`=64'hFFFF_FFFF_FFFF_FFFF, src0 lane0 = 64'h0123456789ABCDEF → lane0 out = 64'hFEDCBA9876543210; lanes 1-4 unchanged.
- `NUM_SRC`=3, accept with `sel_i`=3 → `state_o` = src0 and `err_o`=1. `err_o` stays 1 after further valid requests and clears only on `resetb_i`=0.
- Preload `xfer_cnt_o` to 0xFFFF via 65535 transfers, then one more transfer → `xfer_cnt_o`=0x0000.
- Assert `resetb_i`=0 asynchronously while FULL → `valid_o`=0 and `ready_o`=1 immediately. After release, the first new accept appears one cycle later.
